// File: rtl/mem_read_scan_pkg.sv
// Shared types and sizes for the memory read-scan block.
// STEP_MODE_EN adds the HOLD state used for single-step scanning.
package mem_read_scan_pkg;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEN_MAX = 64;
    localparam int unsigned CNT_W   = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_DONE = 3'd3
`ifdef STEP_MODE_EN
        ,
        ST_HOLD = 3'd4
`endif
    } state_t;

    // A programmed length of zero requests the full 64-word address space.
    function automatic logic [CNT_W-1:0] len_to_count(input logic [ADDR_W-1:0] len);
        return (len == '0) ? CNT_W'(LEN_MAX) : {1'b0, len};
    endfunction

endpackage

// File: rtl/mem_read_scan_if.sv
// Synchronous-read RAM port: address/enable out, read data back one cycle later.
interface mem_read_scan_if;
    import mem_read_scan_pkg::*;

    logic [ADDR_W-1:0] M_Addr;
    logic              M_En;
    logic [DATA_W-1:0] M_R_Data;

    modport master (output M_Addr, output M_En, input M_R_Data);
    modport slave  (input M_Addr, input M_En, output M_R_Data);

endinterface

// File: rtl/mem_read_scan_byte_lane_sel.sv
// Byte-lane multiplexer: picks one byte of a 32-bit word for display.
module byte_lane_sel (
    input  logic [31:0] Data,
    input  logic [1:0]  Select,
    output logic [7:0]  Byte
);

    always_comb begin
        Byte = '0;
        unique case (Select)
            2'b00: Byte = Data[7:0];
            2'b01: Byte = Data[15:8];
            2'b10: Byte = Data[23:16];
            2'b11: Byte = Data[31:24];
            default: Byte = '0;
        endcase
    end

endmodule

// File: rtl/mem_read_scan.sv
// Scans a block of RAM words, keeping a running checksum and the last word.
// Defining STEP_MODE_EN pauses in HOLD after each word until Step is pulsed.
module mem_read_scan
    import mem_read_scan_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic [ADDR_W-1:0]   Base_Addr,
    input  logic [ADDR_W-1:0]   Len,
    input  logic [1:0]          Select,
    input  logic                Step,
    mem_read_scan_if.master     mem,
    output logic [7:0]          LED,
    output logic [DATA_W-1:0]   Checksum,
    output logic                Busy,
    output logic                Done
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic                m_en_q, m_en_d;

`ifndef STEP_MODE_EN
    logic unused_step;
    assign unused_step = Step;
`endif

    // RAM controls are registered on entry to READ so they line up with that state.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        data_d   = data_q;
        sum_d    = sum_q;
        m_addr_d = m_addr_q;
        m_en_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    addr_d   = Base_Addr;
                    count_d  = len_to_count(Len);
                    sum_d    = '0;
                    m_addr_d = Base_Addr;
                    m_en_d   = 1'b1;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                data_d  = mem.M_R_Data;
                sum_d   = sum_q + mem.M_R_Data;
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
`ifdef STEP_MODE_EN
                    state_d = ST_HOLD;
`else
                    m_addr_d = addr_q + ADDR_W'(1);
                    m_en_d   = 1'b1;
                    state_d  = ST_READ;
`endif
                end
            end
`ifdef STEP_MODE_EN
            ST_HOLD: begin
                if (Step) begin
                    m_addr_d = addr_q;
                    m_en_d   = 1'b1;
                    state_d  = ST_READ;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            data_q   <= '0;
            sum_q    <= '0;
            m_addr_q <= '0;
            m_en_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            sum_q    <= sum_d;
            m_addr_q <= m_addr_d;
            m_en_q   <= m_en_d;
        end
    end

    assign mem.M_Addr = m_addr_q;
    assign mem.M_En   = m_en_q;
    assign Checksum   = sum_q;
    assign Busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign Done       = (state_q == ST_DONE);

    byte_lane_sel u_lane (
        .Data   (data_q),
        .Select (Select),
        .Byte   (LED)
    );

endmodule

// File: tb/tb_mem_read_scan.sv
// Directed bench for mem_read_scan with a 1-cycle RAM model and read scoreboard.
// Build with STEP_MODE_EN to exercise the HOLD state.
module tb_mem_read_scan;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [5:0]  Base_Addr;
    logic [5:0]  Len;
    logic [1:0]  Select;
    logic        Step;
    logic [7:0]  LED;
    logic [31:0] Checksum;
    logic        Busy;
    logic        Done;

    mem_read_scan_if bus ();

    mem_read_scan dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Base_Addr (Base_Addr),
        .Len       (Len),
        .Select    (Select),
        .Step      (Step),
        .mem       (bus),
        .LED       (LED),
        .Checksum  (Checksum),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

`ifdef STEP_MODE_EN
    localparam int PERIOD = 3;
`else
    localparam int PERIOD = 2;
`endif

    logic [31:0] ram [64];
    initial begin
        for (int k = 0; k < 64; k++) ram[k] = 32'hA0B0C000 + 32'(k);
    end

    always @(posedge Clk) begin
        if (bus.M_En) bus.M_R_Data <= ram[bus.M_Addr];
    end

    typedef struct {
        logic [5:0] addr;
        int         k;
    } rd_t;

    rd_t         rd_q[$];
    logic [31:0] exp_sum;
    logic [31:0] last_word;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] s);
        return w[8*s +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_addr"}, 32'(bus.M_Addr), 32'd0);
        chk({tag, "_m_en"}, 32'(bus.M_En), 32'd0);
        chk({tag, "_led"}, 32'(LED), 32'd0);
        chk({tag, "_checksum"}, Checksum, 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
    endtask

    // Scoreboard holds expected (address, cycle) per read; abort_k asserts Rst at that cycle.
    task automatic run_scan(input logic [5:0] base, input logic [5:0] len,
                            input int abort_k, input int start_at_k);
        int         n_words;
        int         done_k;
        int         k;
        bit         done_seen;
        logic [5:0] a;
        rd_t        r;

        n_words = (len == 6'd0) ? 64 : int'(len);
        rd_q.delete();
        exp_sum = '0;
        a = base;
        for (int j = 0; j < n_words; j++) begin
            r.addr = a;
            r.k    = 1 + PERIOD * j;
            rd_q.push_back(r);
            last_word = 32'hA0B0C000 + 32'(a);
            exp_sum   = exp_sum + last_word;
            a = a + 6'd1;
        end
        done_k = 1 + PERIOD * (n_words - 1) + 2;

        @(negedge Clk);
        Base_Addr = base;
        Len       = len;
        Start     = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;

        k = 0;
        done_seen = 1'b0;
        while (!done_seen && k < 400) begin
            @(negedge Clk);
            k++;
            if (k == start_at_k) begin
                Base_Addr = 6'h2A;
                Start     = 1'b1;
            end
            if (start_at_k != 0 && k == start_at_k + 1) Start = 1'b0;
            if (k == abort_k) begin
                Rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                rd_q.delete();
                @(negedge Clk);
                Rst = 1'b0;
                return;
            end
            if (k == 1) chk("busy_first", 32'(Busy), 32'd1);
            if (bus.M_En === 1'b1) begin
                if (rd_q.size() == 0) begin
                    chk("spurious_read", 32'(bus.M_Addr), 32'hFFFF_FFFF);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_addr", 32'(bus.M_Addr), 32'(r.addr));
                    chk("rd_cycle", 32'(k), 32'(r.k));
                end
            end
            if (Done === 1'b1) begin
                done_seen = 1'b1;
                chk("done_cycle", 32'(k), 32'(done_k));
                chk("checksum", Checksum, exp_sum);
                chk("led", 32'(LED), 32'(lane(last_word, Select)));
                chk("busy_done", 32'(Busy), 32'd0);
                chk("pending_reads", 32'(rd_q.size()), 32'd0);
            end
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        Rst       = 1'b0;
        Start     = 1'b0;
        Base_Addr = '0;
        Len       = '0;
        Select    = 2'b00;
`ifdef STEP_MODE_EN
        Step      = 1'b1;
`else
        Step      = 1'b0;
`endif

        #3 Rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        // Four words from address 0, then sweep the byte lanes combinationally.
        run_scan(6'd0, 6'd4, 0, 0);
        for (int s = 0; s < 4; s++) begin
            Select = 2'(s);
            #1 chk("led_lane", 32'(LED), 32'(lane(last_word, 2'(s))));
        end
        repeat (3) @(negedge Clk);
        chk("done_hold", 32'(Done), 32'd1);
        chk("checksum_hold", Checksum, exp_sum);
        Select = 2'b00;

        // Address wrap 62, 63, 0.
        run_scan(6'd62, 6'd3, 0, 0);

        // Len 0 scans all 64 words; a Start while busy is ignored.
        run_scan(6'd0, 6'd0, 0, 10);

        // Reset during the third CAPT, then a fresh single-word scan.
        run_scan(6'd0, 6'd8, 2 + PERIOD * 2, 0);
        run_scan(6'd5, 6'd1, 0, 0);

`ifdef STEP_MODE_EN
        Step = 1'b0;
        @(negedge Clk);
        Base_Addr = 6'd10;
        Len       = 6'd2;
        Start     = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        chk("step_rd0_en", 32'(bus.M_En), 32'd1);
        chk("step_rd0_addr", 32'(bus.M_Addr), 32'd10);
        @(negedge Clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("hold_busy", 32'(Busy), 32'd1);
            chk("hold_no_en", 32'(bus.M_En), 32'd0);
        end
        Step = 1'b1;
        @(negedge Clk);
        Step = 1'b0;
        chk("step_rd1_en", 32'(bus.M_En), 32'd1);
        chk("step_rd1_addr", 32'(bus.M_Addr), 32'd11);
        @(negedge Clk);
        @(negedge Clk);
        chk("step_done", 32'(Done), 32'd1);
        chk("step_checksum", Checksum, 32'h4161_8000 + 32'd21);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
